deadtime_driver: RTL

DEADTIME_DRIVER -- requirements
Module: deadtime_driver

---
 rtl/deadtime_driver_pkg.sv | 19 +
 rtl/deadtime_driver_pulse_timer.sv | 35 +++
 rtl/deadtime_driver.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/deadtime_driver_pkg.sv
// Shared switch definitions for the dead-time coil driver: state encoding,
// default widths and a small width helper.
package deadtime_driver_pkg;

  localparam int W_BITS_DEF = 13;
  localparam int D_BITS_DEF = 8;

  typedef enum logic [1:0] {
    LATCH   = 2'd0,
    PULSE_S = 2'd1,
    PULSE_R = 2'd2,
    DEAD    = 2'd3
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/deadtime_driver_pulse_timer.sv
// Loadable down-counter with a done flag, shared by the pulse and dead-time phases.
// Loading N makes done rise N cycles later, so a phase of K cycles loads K-1.
module pulse_timer #(
  parameter int CNT_BITS = 13
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [CNT_BITS-1:0] load_val,
  output logic                done
);

  logic [CNT_BITS-1:0] cnt_q;
  logic [CNT_BITS-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/deadtime_driver.sv
// Set/reset coil driver: fixed-width pulses separated by a dead time, with a
// one-deep request queue, conflict detection and a saturating drop counter.
module deadtime_driver
  import deadtime_driver_pkg::*;
#(
  parameter int W_BITS = W_BITS_DEF,
  parameter int D_BITS = D_BITS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [W_BITS-1:0] W,
  input  logic [D_BITS-1:0] dead,
  input  logic              set_req,
  input  logic              reset_req,
  output logic              signal,
  output logic              signal_b,
  output logic              latch,
  output logic              busy,
  output logic              pending,
  output logic              conflict,
  output logic [D_BITS-1:0] drop_cnt
);

  localparam int CNT_BITS = max_int(W_BITS, D_BITS);

  state_e state_q, state_d;
  logic pending_q, pending_d;
  logic pend_dir_q, pend_dir_d;
  logic signal_q, signal_d;
  logic signal_b_q, signal_b_d;
  logic conflict_q, conflict_d;
  logic [D_BITS-1:0] drop_cnt_q, drop_cnt_d;

  logic                timer_load;
  logic [CNT_BITS-1:0] timer_val;
  logic                timer_done;
  logic [CNT_BITS-1:0] w_load;
  logic [CNT_BITS-1:0] dead_load;

  logic single_req;
  logic both_req;
  logic phase_over;
  logic consume;
  logic direct;
  logic drop_req;

  // W=0 behaves as a one-cycle pulse; dead_load is only used when dead != 0.
  assign w_load    = (W == '0) ? '0 : (CNT_BITS'(W) - 1'b1);
  assign dead_load = CNT_BITS'(dead) - 1'b1;

  pulse_timer #(
    .CNT_BITS(CNT_BITS)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_comb begin
    single_req = set_req ^ reset_req;
    both_req   = set_req & reset_req;
    state_d    = state_q;
    pending_d  = pending_q;
    pend_dir_d = pend_dir_q;
    timer_load = 1'b0;
    timer_val  = w_load;
    phase_over = 1'b0;
    consume    = 1'b0;
    direct     = 1'b0;
    drop_req   = 1'b0;
    drop_cnt_d = drop_cnt_q;
    conflict_d = both_req;

    case (state_q)
      LATCH: phase_over = 1'b1;
      PULSE_S, PULSE_R: begin
        if (timer_done) begin
          if (dead != '0) begin
            state_d    = DEAD;
            timer_load = 1'b1;
            timer_val  = dead_load;
          end else begin
            phase_over = 1'b1;
          end
        end
      end
      DEAD: phase_over = timer_done;
      default: state_d = LATCH;
    endcase

    // A queued request takes priority over a fresh one when the driver frees up.
    if (phase_over) begin
      if (en && pending_q) begin
        consume    = 1'b1;
        state_d    = pend_dir_q ? PULSE_S : PULSE_R;
        timer_load = 1'b1;
        timer_val  = w_load;
      end else if ((state_q == LATCH) && en && single_req) begin
        direct     = 1'b1;
        state_d    = set_req ? PULSE_S : PULSE_R;
        timer_load = 1'b1;
        timer_val  = w_load;
      end else begin
        state_d = LATCH;
      end
    end

    if (consume) begin
      pending_d = 1'b0;
    end

    if (both_req) begin
      drop_req = 1'b1;
    end else if (single_req && !direct && !((state_q == LATCH) && !en)) begin
      if (!pending_q || consume) begin
        pending_d  = 1'b1;
        pend_dir_d = set_req;
      end else begin
        drop_req = 1'b1;
      end
    end

    if (drop_req && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end

    signal_d   = (state_d == PULSE_S);
    signal_b_d = (state_d == PULSE_R);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= LATCH;
      pending_q  <= 1'b0;
      pend_dir_q <= 1'b0;
      signal_q   <= 1'b0;
      signal_b_q <= 1'b0;
      conflict_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      pend_dir_q <= pend_dir_d;
      signal_q   <= signal_d;
      signal_b_q <= signal_b_d;
      conflict_q <= conflict_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign signal   = signal_q;
  assign signal_b = signal_b_q;
  assign latch    = ~signal_q & ~signal_b_q;
  assign busy     = (state_q != LATCH);
  assign pending  = pending_q;
  assign conflict = conflict_q;
  assign drop_cnt = drop_cnt_q;

endmodule
